phy_tx_serdes_n: RTL and testbench

- Parametrised multi-lane PHY transmit serializer.
- Generalises the fixed two-lane, 8-bit TX path to LANES lanes of WIDTH-bit symbols.
- Runs entirely on clk_8f. An internal bit counter replaces the derived clk_f/clk_2f clocks.
- After reset, sends a COM sync burst, then per-lane data or IDLE symbols. Adds per-lane enable and a symbol-request strobe; neither exists in the two-lane path.

---
 rtl/phy_tx_serdes_n.sv | 122 ++++++++++++
 tb/tb_phy_tx_serdes_n.sv | 116 +++++++++++
 2 files changed

// File: rtl/phy_tx_serdes_n.sv
// Multi-lane PHY transmit serializer: COM sync burst after reset, then per-lane data/IDLE symbols.
// Optional periodic SKP insertion is enabled by defining PHY_TX_SKP_EN.
module phy_tx_serdes_n #(
  parameter int unsigned      LANES        = 2,
  parameter int unsigned      WIDTH        = 8,
  parameter logic [WIDTH-1:0] COM_SYM      = 8'hBC,
  parameter logic [WIDTH-1:0] IDL_SYM      = 8'h7C,
  parameter int unsigned      COM_COUNT    = 4,
  parameter logic [WIDTH-1:0] SKP_SYM      = 8'h1C,
  parameter int unsigned      SKP_INTERVAL = 16
) (
  input  logic                   clk_8f,
  input  logic                   reset,
  input  logic [LANES*WIDTH-1:0] data_in,
  input  logic [LANES-1:0]       valid_in,
  input  logic [LANES-1:0]       lane_en,
  output logic                   sym_req,
  output logic [LANES-1:0]       serial_out,
  output logic                   active_out
);

  localparam int unsigned     CntW    = $clog2(WIDTH);
  localparam int unsigned     ComW    = $clog2(COM_COUNT + 1);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);
  localparam logic [ComW-1:0] LastCom = ComW'(COM_COUNT - 1);

  if (WIDTH < 4 || COM_COUNT < 1 || SKP_INTERVAL < 2 || $bits(SKP_SYM) != WIDTH)
  begin : gen_bad_params
    $error("phy_tx_serdes_n: illegal parameter combination");
  end

  typedef enum logic {StSync, StActive} state_e;

  state_e                        state_q, state_d;
  logic [CntW-1:0]               cnt_q, cnt_d;
  logic [ComW-1:0]               com_cnt_q, com_cnt_d;
  logic [LANES-1:0][WIDTH-1:0]   shreg_q, shreg_d;
  logic                          load;
  logic                          skp_slot;

`ifdef PHY_TX_SKP_EN
  localparam int unsigned     SlotW    = $clog2(SKP_INTERVAL);
  localparam logic [SlotW-1:0] LastSlot = SlotW'(SKP_INTERVAL - 1);

  logic [SlotW-1:0] slot_q, slot_d;

  always_ff @(posedge clk_8f) begin
    if (reset) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  // Slot only advances on ACTIVE load edges; the last slot of each period carries SKP.
  always_comb begin
    skp_slot = (slot_q == LastSlot);
    slot_d   = slot_q;
    if (load && state_q == StActive) begin
      slot_d = skp_slot ? '0 : slot_q + SlotW'(1);
    end
  end
`else
  assign skp_slot = 1'b0;
`endif

  always_ff @(posedge clk_8f) begin
    if (reset) begin
      state_q   <= StSync;
      cnt_q     <= LastBit;
      com_cnt_q <= '0;
      shreg_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      com_cnt_q <= com_cnt_d;
      shreg_q   <= shreg_d;
    end
  end

  always_comb begin
    load      = (cnt_q == LastBit);
    cnt_d     = load ? '0 : cnt_q + CntW'(1);
    state_d   = state_q;
    com_cnt_d = com_cnt_q;
    for (int i = 0; i < LANES; i++) begin
      shreg_d[i] = shreg_q[i] << 1;
    end

    if (load) begin
      if (state_q == StSync) begin
        com_cnt_d = com_cnt_q + ComW'(1);
        if (com_cnt_q == LastCom) begin
          state_d = StActive;
        end
      end
      for (int i = 0; i < LANES; i++) begin
        if (!lane_en[i]) begin
          shreg_d[i] = '0;
        end else if (state_q == StSync) begin
          shreg_d[i] = COM_SYM;
        end else if (skp_slot) begin
          shreg_d[i] = SKP_SYM;
        end else if (valid_in[i]) begin
          shreg_d[i] = data_in[i*WIDTH +: WIDTH];
        end else begin
          shreg_d[i] = IDL_SYM;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      serial_out[i] = shreg_q[i][WIDTH-1];
    end
  end

  assign sym_req    = load && (state_q == StActive) && !skp_slot;
  assign active_out = (state_q == StActive);

endmodule

// File: tb/tb_phy_tx_serdes_n.sv
// Directed self-checking bench for phy_tx_serdes_n (default params, SKP_INTERVAL=4 when
// PHY_TX_SKP_EN is defined).
module tb_phy_tx_serdes_n;

  logic        clk_8f = 1'b0;
  logic        reset;
  logic [15:0] data_in;
  logic [1:0]  valid_in;
  logic [1:0]  lane_en;
  logic        sym_req;
  logic [1:0]  serial_out;
  logic        active_out;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk_8f = ~clk_8f;

  phy_tx_serdes_n #(
    .SKP_INTERVAL(4)
  ) dut (
    .clk_8f    (clk_8f),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .lane_en   (lane_en),
    .sym_req   (sym_req),
    .serial_out(serial_out),
    .active_out(active_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Check bits first..last (0 = MSB) of one symbol slot per lane, one cycle per bit.
  task automatic check_bits(input logic [7:0] e1, input logic [7:0] e0, input int first,
                            input int last, input logic req_last, input string tag);
    logic [1:0] exp_bits;
    for (int j = first; j <= last; j++) begin
      @(negedge clk_8f);
      exp_bits = {e1[7-j], e0[7-j]};
      chk({tag, " serial"}, 32'(serial_out), 32'(exp_bits));
      chk({tag, " sym_req"}, 32'(sym_req), (j == 7) ? 32'(req_last) : 32'd0);
      chk({tag, " active"}, 32'(active_out), 32'd1);
    end
  endtask

  task automatic check_burst(input string tag);
    logic [7:0] com;
    logic       b;
    com = 8'hBC;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk_8f);
      b = com[7 - (k % 8)];
      chk({tag, " com serial"}, 32'(serial_out), 32'({b, b}));
      chk({tag, " com active"}, 32'(active_out), (k >= 24) ? 32'd1 : 32'd0);
      chk({tag, " com sym_req"}, 32'(sym_req), (k == 31) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    reset    = 1'b1;
    data_in  = 16'h0000;
    valid_in = 2'b00;
    lane_en  = 2'b11;
    repeat (3) @(negedge clk_8f);
    chk("reset serial", 32'(serial_out), 32'd0);
    chk("reset active", 32'(active_out), 32'd0);
    chk("reset sym_req", 32'(sym_req), 32'd0);
    reset = 1'b0;
    check_burst("burst1");

`ifndef PHY_TX_SKP_EN
    check_bits(8'h7C, 8'h7C, 0, 7, 1'b1, "idle");
    check_bits(8'h7C, 8'h7C, 0, 7, 1'b1, "idle2");
    data_in  = {8'hA5, 8'h3C};
    valid_in = 2'b11;
    check_bits(8'hA5, 8'h3C, 0, 7, 1'b1, "data11");
    valid_in = 2'b01;
    check_bits(8'h7C, 8'h3C, 0, 7, 1'b1, "data01");
    valid_in = 2'b11;
    check_bits(8'hA5, 8'h3C, 0, 3, 1'b1, "en_pre");
    lane_en = 2'b10;
    check_bits(8'hA5, 8'h3C, 4, 7, 1'b1, "en_tail");
    check_bits(8'hA5, 8'h00, 0, 7, 1'b1, "en_off");
    check_bits(8'hA5, 8'h00, 0, 3, 1'b1, "pre_rst");
    reset = 1'b1;
    @(negedge clk_8f);
    chk("midrst serial", 32'(serial_out), 32'd0);
    chk("midrst active", 32'(active_out), 32'd0);
    chk("midrst sym_req", 32'(sym_req), 32'd0);
    lane_en = 2'b11;
    reset   = 1'b0;
    check_burst("burst2");
    check_bits(8'hA5, 8'h3C, 0, 7, 1'b1, "post_rst");
`else
    data_in  = {8'hA5, 8'h3C};
    valid_in = 2'b11;
    check_bits(8'hA5, 8'h3C, 0, 7, 1'b1, "skp s0");
    check_bits(8'hA5, 8'h3C, 0, 7, 1'b1, "skp s1");
    check_bits(8'hA5, 8'h3C, 0, 7, 1'b0, "skp s2");
    check_bits(8'h1C, 8'h1C, 0, 7, 1'b1, "skp s3");
    check_bits(8'hA5, 8'h3C, 0, 7, 1'b1, "skp s4");
    check_bits(8'hA5, 8'h3C, 0, 7, 1'b1, "skp s5");
    check_bits(8'hA5, 8'h3C, 0, 7, 1'b0, "skp s6");
    check_bits(8'h1C, 8'h1C, 0, 7, 1'b1, "skp s7");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
